// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
// Shared definitions for the load/store data-memory front end:
//   - state_e          : access FSM states
//   - FUNCT3_*         : RV32I load/store width/sign codes
//   - MASK_*           : byte-lane masks before the address-offset shift
//   - width_mask()     : funct3 -> lane mask
//   - funct3_undefined : funct3 codes that do not name a load/store width
//   - natural_misaligned : half/word not on its natural boundary
// -----------------------------------------------------------------------------
package memory_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS0 = 2'd1,
        ST_ACCESS1 = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // funct3[2] only selects sign/zero extension, so width comes from [1:0].
    function automatic logic [3:0] width_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            2'b10:   return MASK_W;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic funct3_undefined(input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    function automatic logic natural_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return ((funct3[1:0] == 2'b01) && (off[0] != 1'b0)) ||
               ((funct3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/memory_data_align.sv
// -----------------------------------------------------------------------------
// memory_data_align
// Combinational lane steering for the data-memory bus.
//   Store side: st_funct3_i/st_off_i/st_wdata_i -> st_wdata_o (64-bit shifted
//               data, low word = beat 0) and st_be_o (8-bit lane pattern,
//               low nibble = beat 0).
//   Load side : ld_funct3_i/ld_off_i/ld_rdata_i ({beat1, beat0}) ->
//               ld_data_o (lane-shifted, sign/zero-extended result).
// -----------------------------------------------------------------------------
module memory_data_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_be_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [63:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift_s;

    // Store lanes: the width mask and right-aligned data both move up by the byte offset.
    always_comb begin
        st_be_o    = {4'b0000, width_mask(st_funct3_i)} << st_off_i;
        st_wdata_o = {32'h0000_0000, st_wdata_i} << {st_off_i, 3'b000};
    end

    // Load result: bring the addressed bytes down to bit 0, then extend per funct3.
    always_comb begin
        ld_shift_s = 32'(ld_rdata_i >> {ld_off_i, 3'b000});
        case (ld_funct3_i)
            FUNCT3_B:  ld_data_o = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            FUNCT3_BU: ld_data_o = {24'h00_0000, ld_shift_s[7:0]};
            FUNCT3_H:  ld_data_o = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            FUNCT3_HU: ld_data_o = {16'h0000, ld_shift_s[15:0]};
            FUNCT3_W:  ld_data_o = ld_shift_s;
            default:   ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
// Data-memory front end: captures one load/store from execute, runs it as one
// or two word beats on the data bus, and returns a one-cycle response.
//   Request : req_valid/req_ready handshake, req_write, req_funct3,
//             req_address, req_wdata
//   Bus     : mem_req, mem_we, mem_addr (word aligned), mem_be, mem_wdata,
//             mem_ack, mem_rdata
//   Response: resp_valid pulse with resp_rdata, resp_misaligned, resp_bus_error
// Parameter ACK_TIMEOUT: cycles a beat may wait for mem_ack (0 = no limit).
// Build option MEM_MISALIGNED_SPLIT_EN: when defined, misaligned accesses are
// executed (word-crossing ones as two beats) instead of being rejected.
// All outputs are registered; reset is asynchronous active-low.
// -----------------------------------------------------------------------------
module memory_access_unit
    import memory_access_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_bus_error
);

    // Last counter value before a beat is abandoned.
    localparam logic [7:0] TO_LIMIT = (ACK_TIMEOUT == 32'd0) ? 8'd0 : 8'(ACK_TIMEOUT - 32'd1);

    state_e      state_r;
    logic [29:0] addr_word_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic        write_r;
    logic [7:0]  be8_r;
    logic [63:0] wdata64_r;
    logic [31:0] rdata0_r;
    logic [7:0]  cnt_r;

    logic [63:0] st_wdata_s;
    logic [7:0]  st_be_s;
    logic [63:0] ld_rdata_s;
    logic [31:0] ld_data_s;
    logic        req_illegal_s;
    logic        timeout_s;

    // The store side steers the incoming request so the beat-0 lanes can be registered at acceptance.
    memory_data_align u_align (
        .st_funct3_i (req_funct3),
        .st_off_i    (req_address[1:0]),
        .st_wdata_i  (req_wdata),
        .st_wdata_o  (st_wdata_s),
        .st_be_o     (st_be_s),
        .ld_funct3_i (funct3_r),
        .ld_off_i    (off_r),
        .ld_rdata_i  (ld_rdata_s),
        .ld_data_o   (ld_data_s)
    );

    // Load window: a second beat pairs the live word with the held beat-0 word.
    always_comb begin
        ld_rdata_s = {32'h0000_0000, mem_rdata};
        if (state_r == ST_ACCESS1) begin
            ld_rdata_s = {mem_rdata, rdata0_r};
        end else begin
            ld_rdata_s = {32'h0000_0000, mem_rdata};
        end
    end

    // Request legality: undefined widths always fail; alignment only matters without splitting.
    always_comb begin
        req_illegal_s = 1'b0;
`ifdef MEM_MISALIGNED_SPLIT_EN
        req_illegal_s = funct3_undefined(req_funct3);
`else
        req_illegal_s = funct3_undefined(req_funct3) ||
                        natural_misaligned(req_funct3, req_address[1:0]);
`endif
    end

    // Beat timeout flag; a zero limit disables it.
    always_comb begin
        timeout_s = 1'b0;
        if (ACK_TIMEOUT != 32'd0) begin
            timeout_s = (cnt_r == TO_LIMIT);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Access FSM with capture registers, timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            addr_word_r     <= 30'd0;
            funct3_r        <= 3'b000;
            off_r           <= 2'b00;
            write_r         <= 1'b0;
            be8_r           <= 8'h00;
            wdata64_r       <= 64'h0;
            rdata0_r        <= 32'h0000_0000;
            cnt_r           <= 8'd0;
            req_ready       <= 1'b1;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'h0000_0000;
            mem_be          <= 4'b0000;
            mem_wdata       <= 32'h0000_0000;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'h0000_0000;
            resp_misaligned <= 1'b0;
            resp_bus_error  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_word_r <= req_address[31:2];
                        funct3_r    <= req_funct3;
                        off_r       <= req_address[1:0];
                        write_r     <= req_write;
                        be8_r       <= st_be_s;
                        wdata64_r   <= st_wdata_s;
                        req_ready   <= 1'b0;
                        cnt_r       <= 8'd0;
                        if (req_illegal_s) begin
                            state_r         <= ST_RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= 32'h0000_0000;
                            resp_misaligned <= 1'b1;
                        end else begin
                            state_r   <= ST_ACCESS0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {req_address[31:2], 2'b00};
                            mem_be    <= st_be_s[3:0];
                            mem_wdata <= st_wdata_s[31:0];
                        end
                    end
                end
                ST_ACCESS0, ST_ACCESS1: begin
                    if (mem_ack) begin
                        cnt_r <= 8'd0;
                        if ((state_r == ST_ACCESS0) && (be8_r[7:4] != 4'b0000)) begin
                            // Word-crossing: second beat on the next word, wrapping at 2^32.
                            state_r   <= ST_ACCESS1;
                            rdata0_r  <= mem_rdata;
                            mem_addr  <= {addr_word_r + 30'd1, 2'b00};
                            mem_be    <= be8_r[7:4];
                            mem_wdata <= wdata64_r[63:32];
                        end else begin
                            state_r    <= ST_RESP;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= 32'h0000_0000;
                            mem_be     <= 4'b0000;
                            mem_wdata  <= 32'h0000_0000;
                            resp_valid <= 1'b1;
                            resp_rdata <= write_r ? 32'h0000_0000 : ld_data_s;
                        end
                    end else if (timeout_s) begin
                        // A completed first beat of a split store stays written.
                        state_r        <= ST_RESP;
                        mem_req        <= 1'b0;
                        mem_we         <= 1'b0;
                        mem_addr       <= 32'h0000_0000;
                        mem_be         <= 4'b0000;
                        mem_wdata      <= 32'h0000_0000;
                        resp_valid     <= 1'b1;
                        resp_rdata     <= 32'h0000_0000;
                        resp_bus_error <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_r         <= ST_IDLE;
                    req_ready       <= 1'b1;
                    resp_valid      <= 1'b0;
                    resp_rdata      <= 32'h0000_0000;
                    resp_misaligned <= 1'b0;
                    resp_bus_error  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_access_unit
// Directed bench for memory_access_unit (ACK_TIMEOUT = 4). Expectations for the
// misaligned cases follow MEM_MISALIGNED_SPLIT_EN as defined for the build.
// -----------------------------------------------------------------------------
module tb_memory_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    memory_access_unit #(.ACK_TIMEOUT(32'd4)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_bus_error  (resp_bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack_beat(input logic [31:0] rd);
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        chk({tag, "_mem_req"},   {63'd0, mem_req}, 64'd1);
        chk({tag, "_mem_we"},    {63'd0, mem_we}, {63'd0, we});
        chk({tag, "_mem_addr"},  {32'd0, mem_addr}, {32'd0, a});
        chk({tag, "_mem_be"},    {60'd0, mem_be}, {60'd0, be});
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, {32'd0, wd});
        chk({tag, "_no_resp"},   {63'd0, resp_valid}, 64'd0);
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] rd, input logic mis, input logic berr);
        chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, "_mem_req_low"}, {63'd0, mem_req}, 64'd0);
        chk({tag, "_resp_rdata"}, {32'd0, resp_rdata}, {32'd0, rd});
        chk({tag, "_resp_mis"},   {63'd0, resp_misaligned}, {63'd0, mis});
        chk({tag, "_resp_berr"},  {63'd0, resp_bus_error}, {63'd0, berr});
        tick();
        chk({tag, "_pulse_end"},  {63'd0, resp_valid}, 64'd0);
        chk({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_mem_req"},   {63'd0, mem_req}, 64'd0);
        chk({tag, "_mem_we"},    {63'd0, mem_we}, 64'd0);
        chk({tag, "_mem_addr"},  {32'd0, mem_addr}, 64'd0);
        chk({tag, "_mem_be"},    {60'd0, mem_be}, 64'd0);
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_resp_rdata"}, {32'd0, resp_rdata}, 64'd0);
        chk({tag, "_resp_mis"},  {63'd0, resp_misaligned}, 64'd0);
        chk({tag, "_resp_berr"}, {63'd0, resp_bus_error}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_address = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

        #12;
        chk_all_idle("reset");
        reset = 1'b1;
        tick();

        // SW 0xDEADBEEF to 0x100, immediate ack: resp at N+2
        accept(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        chk_bus("sw", 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        ack_beat(32'h0);
        chk_resp("sw", 32'h0, 1'b0, 1'b0);

        // LB / LBU at 0x103
        accept(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        chk_bus("lb", 1'b0, 32'h0000_0100, 4'b1000, 32'h0);
        ack_beat(32'h80FF_FFFF);
        chk_resp("lb", 32'hFFFF_FF80, 1'b0, 1'b0);

        accept(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        chk_bus("lbu", 1'b0, 32'h0000_0100, 4'b1000, 32'h0);
        ack_beat(32'h80FF_FFFF);
        chk_resp("lbu", 32'h0000_0080, 1'b0, 1'b0);

        // LH / LHU at 0x102 (aligned half)
        accept(1'b0, 3'b001, 32'h0000_0102, 32'h0);
        chk_bus("lh", 1'b0, 32'h0000_0100, 4'b1100, 32'h0);
        ack_beat(32'h8001_1234);
        chk_resp("lh", 32'hFFFF_8001, 1'b0, 1'b0);

        accept(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        ack_beat(32'h8001_1234);
        chk_resp("lhu", 32'h0000_8001, 1'b0, 1'b0);

        // SB 0xA5 at 0x101
        accept(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5);
        chk_bus("sb", 1'b1, 32'h0000_0100, 4'b0010, 32'h0000_A500);
        ack_beat(32'h0);
        chk_resp("sb", 32'h0, 1'b0, 1'b0);

        // LW at 0x204 with one wait cycle: resp at N+3
        accept(1'b0, 3'b010, 32'h0000_0204, 32'h0);
        chk_bus("lw_wait0", 1'b0, 32'h0000_0204, 4'b1111, 32'h0);
        tick();
        chk_bus("lw_wait1", 1'b0, 32'h0000_0204, 4'b1111, 32'h0);
        ack_beat(32'h1234_5678);
        chk_resp("lw_wait", 32'h1234_5678, 1'b0, 1'b0);

        // Undefined funct3 is rejected in every build
        accept(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        chk_resp("undef_f3", 32'h0, 1'b1, 1'b0);

        // Ack while no request is outstanding is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk_all_idle("stray_ack");

`ifdef MEM_MISALIGNED_SPLIT_EN
        // LW at 0x102 split over two beats: resp at N+3
        accept(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        chk_bus("lw_split0", 1'b0, 32'h0000_0100, 4'b1100, 32'h0);
        ack_beat(32'h4433_1111);
        chk_bus("lw_split1", 1'b0, 32'h0000_0104, 4'b0011, 32'h0);
        ack_beat(32'h2222_6655);
        chk_resp("lw_split", 32'h6655_4433, 1'b0, 1'b0);

        // SH 0xABCD at 0xFFFFFFFF wraps to address 0 for beat 1
        accept(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_ABCD);
        chk_bus("sh_wrap0", 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hCD00_0000);
        ack_beat(32'h0);
        chk_bus("sh_wrap1", 1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00AB);
        ack_beat(32'h0);
        chk_resp("sh_wrap", 32'h0, 1'b0, 1'b0);

        // LH at off 1 stays within one word: single beat
        accept(1'b0, 3'b001, 32'h0000_0101, 32'h0);
        chk_bus("lh_off1", 1'b0, 32'h0000_0100, 4'b0110, 32'h0);
        ack_beat(32'h11F0_0122);
        chk_resp("lh_off1", 32'hFFFF_F001, 1'b0, 1'b0);
`else
        // Misaligned LW and SH rejected with no bus activity: resp at N+1
        accept(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        chk_resp("lw_mis", 32'h0, 1'b1, 1'b0);

        accept(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_ABCD);
        chk_resp("sh_mis", 32'h0, 1'b1, 1'b0);
`endif

        // Timeout: no ack for 4 cycles ends the access with a bus error
        accept(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        chk_bus("to_c1", 1'b0, 32'h0000_0300, 4'b1111, 32'h0);
        tick();
        tick();
        tick();
        chk_bus("to_c4", 1'b0, 32'h0000_0300, 4'b1111, 32'h0);
        tick();
        chk_resp("timeout", 32'h0, 1'b0, 1'b1);

        // Reset during ACCESS0: outputs clear without a clock edge
        accept(1'b1, 3'b010, 32'h0000_0400, 32'h5555_AAAA);
        chk_bus("rst_pre", 1'b1, 32'h0000_0400, 4'b1111, 32'h5555_AAAA);
        #2;
        reset = 1'b0;
        #1;
        chk_all_idle("rst_mid");
        #2;
        reset = 1'b1;
        tick();
        chk_all_idle("rst_after");

        // Recovery after reset
        accept(1'b0, 3'b010, 32'h0000_0008, 32'h0);
        chk_bus("recover", 1'b0, 32'h0000_0008, 4'b1111, 32'h0);
        ack_beat(32'hCAFE_F00D);
        chk_resp("recover", 32'hCAFE_F00D, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Data-memory front end of the phoeniX load/store path: consumes the load/store effective address produced by the address generator, together with funct3 and store data, and executes the access on the word-wide data-memory bus. Stores get byte enables and data lanes generated from the address offset; loads get lane-shifted and sign- or zero-extended results. Sits between the execute stage and the data memory. Stalls the pipeline through a valid/ready handshake.

## Interface
- ACK_TIMEOUT, 255: maximum cycles `mem_req` may wait for `mem_ack` (8-bit counter); 0 disables the timeout.
- clk  in  1  core clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request from execute.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- req_address  in  32  effective byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_req  out  1  bus request; held until `mem_ack`.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned bus address (bits [1:0] = 0).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_ack  in  1  access complete; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  read word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_misaligned  out  1  misaligned-access error; qualified by `resp_valid`.
- resp_bus_error  out  1  timeout error; qualified by `resp_valid`.

## Operation
- States: IDLE, ACCESS0, ACCESS1, RESP.
- IDLE:
  - `req_valid && req_ready` captures address, funct3, write and wdata.
  - A legal request goes to ACCESS0.
  - An illegal request goes directly to RESP with `resp_misaligned = 1` and no bus activity.
- Offset and width: off = address[1:0]; mask = 0001 / 0011 / 1111 for byte / half / word. The 8-bit `mask << off` gives the lane pattern: low nibble is beat 0, high nibble is beat 1.
- A word-crossing access has a non-zero high nibble.
- ACCESS0:
  - `mem_addr = {address[31:2], 2'b00}`, `mem_be` = low nibble.
  - `mem_wdata` = low 32 bits of `{32'b0, wdata} << 8*off`.
  - On `mem_ack`: go to ACCESS1 if the access crosses a word boundary, else to RESP.
- ACCESS1:
  - `mem_addr = {address[31:2], 2'b00} + 4`, with modulo-2^32 wrap, so 0xFFFFFFFE+ accesses wrap to 0x00000000.
  - `mem_be` = high nibble; `mem_wdata` = high 32 bits of the shifted data.
- Load assembly: `{rdata_beat1, rdata_beat0} >> 8*off`, then the low byte or half is sign-extended (funct3[2] = 0) or zero-extended (funct3[2] = 1).
- Beat-0 read data is registered.
- Undefined funct3 values (011, 110, 111) are treated as misaligned.
- `mem_req` is deasserted in the cycle after `mem_ack`. `mem_ack` while `mem_req` is low is ignored.
- Timeout:
  - The counter clears on every beat start.
  - At ACK_TIMEOUT cycles without `mem_ack`, `mem_req` drops and the FSM goes to RESP with `resp_bus_error = 1`.
  - A partially completed split store is not rolled back.
- RESP: `resp_valid = 1` for exactly one cycle, then IDLE.
- Asynchronous reset low, including mid-access: state goes to IDLE and every output is 0 except `req_ready = 1`. `mem_req` drops immediately.

## Timing
- Acceptance at edge N. `mem_req` is high from cycle N+1.
- Aligned access with immediate ack: `resp_valid` at N+2.
- Split access with immediate acks: `resp_valid` at N+3.
- Misaligned rejection: `resp_valid` at N+1.
- Each wait cycle on `mem_ack` adds one cycle.
- Back-to-back: the next request is accepted at the edge after `resp_valid`.
- All bus outputs are registered or decoded from registered state only; there is no combinational path from `req_*` to `mem_*`.
- `resp_rdata` is valid only while `resp_valid` is high.

## Configuration
- MEM_MISALIGNED_SPLIT_EN defined:
  - Every access is legal.
  - Misaligned accesses that stay within one word (e.g. LH at off = 1, `mem_be = 0110`) take one beat.
  - Word-crossing accesses take two beats.
- MEM_MISALIGNED_SPLIT_EN undefined:
  - Half with address[0] ≠ 0, and word with address[1:0] ≠ 0, produce `resp_misaligned`.
  - ACCESS1 is unreachable and may be optimised out.

## Structure
- Shared package `memory_access_pkg` holds:
  - state enum;
  - funct3 constants (FUNCT3_B, H, W, BU, HU);
  - mask constants.
- Sub-module `memory_data_align` is combinational and contains:
  - store lane shift producing the 64-bit shifted word and 8-bit enable;
  - load shift and extension.
- The FSM, timeout counter and capture registers live in the top.

## Test plan
- SW 0xDEADBEEF to 0x100, ack in the first request cycle -> `mem_addr = 0x100`, `mem_be = 1111`, `mem_wdata = 0xDEADBEEF`; `resp_valid` two cycles after acceptance.
- LB at 0x103 with `mem_rdata = 0x80FFFFFF` -> `mem_be = 1000`; `resp_rdata = 0xFFFFFF80`. LBU at the same address -> 0x00000080.
- LW at 0x102 with split enabled, rdata 0x4433xxxx then 0xxxxx6655:
  - beats at 0x100 (be 1100) and 0x104 (be 0011);
  - `resp_rdata = 0x66554433`, `resp_valid` at N+3.
- Same LW with split disabled -> no `mem_req`; `resp_valid` and `resp_misaligned` at N+1.
- SH 0xABCD to 0xFFFFFFFF, split enabled -> beat 0 at 0xFFFFFFFC (be 1000, wdata 0xCD000000), beat 1 at 0x00000000 (be 0001, wdata 0x000000AB).
- ACK_TIMEOUT = 4 with `mem_ack` never asserted -> `mem_req` drops after 4 cycles and `resp_bus_error = 1`. A separate run pulses reset low during ACCESS0 -> all outputs 0 and `req_ready = 1` immediately.
